// File: rtl/fixed_point_accumulator.sv
// Streaming Q8.7 product accumulator with guard bits, sticky overflow and valid/ready result.
// Define SATURATE_EN to saturate the narrowed result instead of wrapping it.
module fixed_point_accumulator #(
  parameter int WIDTH   = 16,
  parameter int FRAC    = 7,
  parameter int GUARD   = 8,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_ovf,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_ovf,
  output logic [COUNT_W-1:0] out_count
);

  localparam int AW = WIDTH + GUARD;
  localparam logic [AW-1:0]    ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0]    ACC_MIN = {1'b1, {(AW-1){1'b0}}};
  localparam logic [WIDTH-1:0] OUT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] OUT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // The binary point is only carried through; it must still lie inside the word.
  if (FRAC >= WIDTH) begin : g_bad_frac
    $error("FRAC must be smaller than WIDTH");
  end

  typedef enum logic {ST_ACCUM, ST_HOLD} state_t;

  state_t             r_state;
  logic [AW-1:0]      r_acc;
  logic               r_sticky;
  logic [COUNT_W-1:0] r_count;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic               r_out_ovf;
  logic [COUNT_W-1:0] r_out_count;

  logic               w_accept;
  logic [AW-1:0]      w_in_ext;
  logic [AW-1:0]      w_sum;
  logic               w_acc_ovf;
  logic [AW-1:0]      w_acc_next;
  logic               w_sticky_next;
  logic [COUNT_W-1:0] w_count_next;
  logic               w_narrow_ovf;
  logic [WIDTH-1:0]   w_data_narrow;

  assign w_accept      = in_valid & (r_state == ST_ACCUM) & ~clear;
  assign w_in_ext      = {{GUARD{in_data[WIDTH-1]}}, in_data};
  assign w_sum         = r_acc + w_in_ext;
  assign w_acc_ovf     = (r_acc[AW-1] == w_in_ext[AW-1]) && (w_sum[AW-1] != r_acc[AW-1]);
  assign w_acc_next    = w_acc_ovf ? (r_acc[AW-1] ? ACC_MIN : ACC_MAX) : w_sum;
  assign w_sticky_next = r_sticky | in_ovf | w_acc_ovf;
  assign w_count_next  = (&r_count) ? r_count : r_count + 1'b1;

  // The top GUARD+1 bits must all equal the sign bit for the sum to fit in WIDTH bits.
  assign w_narrow_ovf  = !((&w_acc_next[AW-1:WIDTH-1]) || !(|w_acc_next[AW-1:WIDTH-1]));

`ifdef SATURATE_EN
  assign w_data_narrow = w_narrow_ovf ? (w_acc_next[AW-1] ? OUT_MIN : OUT_MAX)
                                      : w_acc_next[WIDTH-1:0];
`else
  assign w_data_narrow = w_acc_next[WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ACCUM;
      r_acc       <= '0;
      r_sticky    <= 1'b0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
      r_out_count <= '0;
    end else if (clear) begin
      r_state     <= ST_ACCUM;
      r_acc       <= '0;
      r_sticky    <= 1'b0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
      r_out_count <= '0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            r_acc    <= w_acc_next;
            r_sticky <= w_sticky_next;
            r_count  <= w_count_next;
            if (in_last) begin
              // Result is captured from the final sum so it is valid one cycle after the last beat.
              r_state     <= ST_HOLD;
              r_out_valid <= 1'b1;
              r_out_data  <= w_data_narrow;
              r_out_ovf   <= w_sticky_next | w_narrow_ovf;
              r_out_count <= w_count_next;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_sticky    <= 1'b0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
            r_out_count <= '0;
          end
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_ACCUM);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;
  assign out_count = r_out_count;

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Directed + randomized bench for fixed_point_accumulator against an integer-arithmetic model.
module tb_fixed_point_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_ovf = 1'b0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_ovf;
  logic [7:0]  out_count;

  int n_cmp = 0;
  int n_err = 0;

  longint model_sum;
  bit     model_sticky;
  int     model_count;

  localparam longint ACC_MAX = (64'sd1 <<< 23) - 1;
  localparam longint ACC_MIN = -(64'sd1 <<< 23);

  fixed_point_accumulator dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_ovf(in_ovf), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    model_sum = 0;
    model_sticky = 0;
    model_count = 0;
  endtask

  // Exact integer sum, clamped to the 24-bit signed accumulator range.
  task automatic model_add(input logic [15:0] d, input logic ovf);
    model_sum = model_sum + longint'($signed(d));
    if (model_sum > ACC_MAX) begin model_sum = ACC_MAX; model_sticky = 1; end
    if (model_sum < ACC_MIN) begin model_sum = ACC_MIN; model_sticky = 1; end
    if (ovf) model_sticky = 1;
    if (model_count < 255) model_count++;
  endtask

  task automatic model_expect(output logic [15:0] d, output logic o, output logic [7:0] c);
    logic [63:0] raw;
    bit narrow;
    raw = model_sum;
    narrow = (model_sum > 32767) || (model_sum < -32768);
`ifdef SATURATE_EN
    d = narrow ? ((model_sum > 0) ? 16'h7FFF : 16'h8000) : raw[15:0];
`else
    d = raw[15:0];
`endif
    o = model_sticky | narrow;
    c = model_count[7:0];
  endtask

  task automatic send_beat(input logic [15:0] d, input logic ovf, input logic last);
    int w = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_ovf = ovf; in_last = last;
    while (in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_ovf = 1'b0; in_last = 1'b0;
    model_add(d, ovf);
  endtask

  // Called right after the last beat: checks latency-1 result against given values.
  task automatic check_result(input string tag, input logic [15:0] d, input logic o, input logic [7:0] c);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"}, {16'd0, out_data}, {16'd0, d});
    check({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, o});
    check({tag, "_count"}, {24'd0, out_count}, {24'd0, c});
    $display("batch %s: data=%h ovf=%0d count=%0d", tag, out_data, out_ovf, out_count);
  endtask

  task automatic check_model(input string tag);
    logic [15:0] d; logic o; logic [7:0] c;
    model_expect(d, o, c);
    check_result(tag, d, o, c);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    check({tag, "_no_bypass"}, {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_drop_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    model_reset();
  endtask

  initial begin
    logic [15:0] d; logic o; logic [7:0] c;
    int len;
    model_reset();

    // Reset state
    #12;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {16'd0, out_data}, 32'd0);
    check("rst_ovf", {31'd0, out_ovf}, 32'd0);
    check("rst_count", {24'd0, out_count}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic sum
    send_beat(16'h0080, 0, 0);
    send_beat(16'h0040, 0, 0);
    send_beat(16'hFFC0, 0, 1);
    check_result("basic", 16'h0080, 1'b0, 8'd3);
    handshake("basic");

    // Narrowing: 200 x 0x7FFF
    for (int i = 0; i < 200; i++) send_beat(16'h7FFF, 0, (i == 199));
`ifdef SATURATE_EN
    check_result("narrow", 16'h7FFF, 1'b1, 8'd200);
`else
    check_result("narrow", 16'hFF38, 1'b1, 8'd200);
`endif
    handshake("narrow");

    // Accumulator clamp and count saturation: 300 x 0x7FFF, then 300 x 0x8000
    for (int i = 0; i < 300; i++) send_beat(16'h7FFF, 0, (i == 299));
`ifdef SATURATE_EN
    check_result("clamp_pos", 16'h7FFF, 1'b1, 8'd255);
`else
    check_result("clamp_pos", 16'hFFFF, 1'b1, 8'd255);
`endif
    handshake("clamp_pos");
    for (int i = 0; i < 300; i++) send_beat(16'h8000, 0, (i == 299));
`ifdef SATURATE_EN
    check_result("clamp_neg", 16'h8000, 1'b1, 8'd255);
`else
    check_result("clamp_neg", 16'h0000, 1'b1, 8'd255);
`endif
    handshake("clamp_neg");

    // Sticky flag then clean batch
    send_beat(16'h0010, 1, 0);
    send_beat(16'h0010, 0, 1);
    check_result("sticky", 16'h0020, 1'b1, 8'd2);
    handshake("sticky");
    send_beat(16'h0005, 0, 1);
    check_result("clean", 16'h0005, 1'b0, 8'd1);
    handshake("clean");

    // Backpressure with in_valid held high
    send_beat(16'h0011, 0, 0);
    send_beat(16'h0022, 0, 1);
    check_result("bp", 16'h0033, 1'b0, 8'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'h0003; in_last = 1'b1;
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_data_stable", {16'd0, out_data}, 32'h0033);
      check("bp_count_stable", {24'd0, out_count}, 32'd2);
      check("bp_valid_stable", {31'd0, out_valid}, 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    model_reset();
    check("bp_ready_after_hs", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    model_add(16'h0003, 0);
    check_result("bp_next", 16'h0003, 1'b0, 8'd1);
    handshake("bp_next");

    // clear mid-batch with a beat presented
    send_beat(16'h0400, 0, 0);
    send_beat(16'h0400, 0, 0);
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; in_data = 16'h1234; in_last = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    model_reset();
    check("clear_no_result", {31'd0, out_valid}, 32'd0);
    check("clear_in_ready", {31'd0, in_ready}, 32'd1);
    send_beat(16'h0100, 0, 1);
    check_result("after_clear", 16'h0100, 1'b0, 8'd1);
    handshake("after_clear");

    // clear while holding a result
    send_beat(16'h0042, 0, 1);
    check_model("hold_clear");
    @(negedge clk); clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
    model_reset();
    check("hold_clear_valid", {31'd0, out_valid}, 32'd0);
    check("hold_clear_ready", {31'd0, in_ready}, 32'd1);

    // Randomized batches
    for (int b = 0; b < 10; b++) begin
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) d = 16'($urandom);
        else d = 16'($signed(12'($urandom)));
        o = ($urandom_range(0, 15) == 0);
        send_beat(d, o, (i == len - 1));
      end
      check_model($sformatf("rand%0d", b));
      for (int k = $urandom_range(0, 2); k > 0; k--) @(negedge clk);
      handshake($sformatf("rand%0d", b));
    end

    // Async reset during HOLD
    send_beat(16'h0077, 0, 1);
    model_expect(d, o, c);
    check_result("pre_reset", d, o, c);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_count", {24'd0, out_count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
